block_unstacker_db: RTL and testbench

- Double-buffered 128-bit to 32-bit stream serializer on the read side of the AES engine datapath.
- Takes finished 128-bit blocks from the cipher core and emits four 32-bit words per block toward the HWPE streamer.
- Two block slots (ping-pong) let the core hand off the next block while the current one is still draining.
- Adds a last-word marker and an occupancy status output.

---
 rtl/block_unstacker_db.sv | 102 ++++++++++
 tb/tb_block_unstacker_db.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_unstacker_db.sv
// Ping-pong buffered 128-bit to 32-bit stream serializer.
// Holds up to two blocks and drains four words per block with a last-word marker.
module block_unstacker_db #(
   parameter bit LSW_FIRST = 1'b1,
   parameter bit BYTE_SWAP = 1'b0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         enable_i,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [127:0] block_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [31:0]  word_o,
   output logic         last_o,
   output logic [1:0]   occupancy_o
);

   localparam int unsigned BLK_W  = 128;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned IDX_W  = 2;
   localparam int unsigned OCC_W  = 2;

   logic [BLK_W-1:0]  r_slot [2];
   logic              r_wptr;
   logic              r_rptr;
   logic [IDX_W-1:0]  r_widx;
   logic [OCC_W-1:0]  r_occ;

   logic              w_push;
   logic              w_pop;
   logic              w_pop_last;
   logic [IDX_W-1:0]  w_kidx;
   logic [BLK_W-1:0]  w_blk;
   logic [WORD_W-1:0] w_word;
   logic [WORD_W-1:0] w_word_sw;

   // Handshakes depend only on registered occupancy and the enable gate.
   assign ready_o    = enable_i && (r_occ < OCC_W'(2));
   assign valid_o    = enable_i && (r_occ != '0);
   assign w_push     = valid_i && ready_o;
   assign w_pop      = valid_o && ready_i;
   assign w_pop_last = w_pop && (r_widx == IDX_W'(3));

   // MSW-first order walks the block from the top word down.
   assign w_kidx = LSW_FIRST ? r_widx : ~r_widx;
   assign w_blk  = r_slot[r_rptr];
   assign w_word = w_blk[WORD_W*w_kidx +: WORD_W];

   always_comb begin
      w_word_sw = w_word;
      if (BYTE_SWAP) begin
         w_word_sw = {w_word[7:0], w_word[15:8], w_word[23:16], w_word[31:24]};
      end
   end

   assign word_o      = (r_occ == '0) ? '0 : w_word_sw;
   assign last_o      = valid_o && (r_widx == IDX_W'(3));
   assign occupancy_o = r_occ;

   // Control state; soft clear behaves exactly like reset.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_wptr <= 1'b0;
         r_rptr <= 1'b0;
         r_widx <= '0;
         r_occ  <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= ~r_wptr;
         end
         if (w_pop) begin
            r_widx <= r_widx + IDX_W'(1);
            if (w_pop_last) begin
               r_rptr <= ~r_rptr;
            end
         end
         case ({w_push, w_pop_last})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Slot storage carries no reset; stale data is masked by occupancy.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !clr_i && w_push) begin
         r_slot[r_wptr] <= block_i;
      end
   end

   // An underflow would wrap to 3, so one bound check covers both directions.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (r_occ <= OCC_W'(2));
      end
   end

endmodule

// File: tb/tb_block_unstacker_db.sv
// Bench for block_unstacker_db: a word-order table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_block_unstacker_db;

   localparam logic [127:0] BLK1 = 128'h55555555_12345678_BBBBBBBB_AAAAAAAA;
   localparam logic [127:0] BLK2 = 128'h12345678_00000000_00000000_FFFFFFFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, clr, en, vi, ri;
   logic [127:0] blk;
   logic         rdy0, val0, last0, rdy1, val1, last1;
   logic [31:0]  wd0, wd1;
   logic [1:0]   occ0, occ1;

   block_unstacker_db #(.LSW_FIRST(1'b1), .BYTE_SWAP(1'b0)) u0 (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .enable_i(en), .valid_i(vi),
      .ready_o(rdy0), .block_i(blk), .valid_o(val0), .ready_i(ri),
      .word_o(wd0), .last_o(last0), .occupancy_o(occ0));

   block_unstacker_db #(.LSW_FIRST(1'b0), .BYTE_SWAP(1'b1)) u1 (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .enable_i(en), .valid_i(vi),
      .ready_o(rdy1), .block_i(blk), .valid_o(val1), .ready_i(ri),
      .word_o(wd1), .last_o(last1), .occupancy_o(occ1));

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: FIFO of buffered blocks plus the word index of the head.
   logic [127:0] mq[$];
   int           mw = 0;
   logic [127:0] src[$];

   typedef struct {
      logic         vi;
      logic [127:0] blk;
      logic         ev;
      logic [31:0]  ew0;
      logic [31:0]  ew1;
      logic         el;
      logic [1:0]   eo;
      logic         er;
   } vec_t;
   vec_t tbl[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [31:0] exp_word(input logic [127:0] b, input int idx,
                                            input bit lsw, input bit bs);
      int k;
      logic [31:0] w;
      k = lsw ? idx : 3 - idx;
      w = b[32*k +: 32];
      if (bs) w = {w[7:0], w[15:8], w[23:16], w[31:24]};
      return w;
   endfunction

   task automatic check_model(input string tag);
      logic ev, er, el;
      logic [1:0] eo;
      logic [31:0] e0, e1;
      eo = 2'(mq.size());
      ev = en && (mq.size() > 0);
      er = en && (mq.size() < 2);
      el = ev && (mw == 3);
      e0 = '0;
      e1 = '0;
      if (mq.size() > 0) begin
         e0 = exp_word(mq[0], mw, 1'b1, 1'b0);
         e1 = exp_word(mq[0], mw, 1'b0, 1'b1);
      end
      chk({tag, ".u0.ready"}, 32'(rdy0),  32'(er));
      chk({tag, ".u0.valid"}, 32'(val0),  32'(ev));
      chk({tag, ".u0.word"},  wd0,        e0);
      chk({tag, ".u0.last"},  32'(last0), 32'(el));
      chk({tag, ".u0.occ"},   32'(occ0),  32'(eo));
      chk({tag, ".u1.ready"}, 32'(rdy1),  32'(er));
      chk({tag, ".u1.valid"}, 32'(val1),  32'(ev));
      chk({tag, ".u1.word"},  wd1,        e1);
      chk({tag, ".u1.last"},  32'(last1), 32'(el));
      chk({tag, ".u1.occ"},   32'(occ1),  32'(eo));
   endtask

   task automatic drive(input logic r, input logic c, input logic e, input logic v,
                        input logic [127:0] b, input logic rr);
      rst = r; clr = c; en = e; vi = v; blk = b; ri = rr;
      #1;
   endtask

   // Clock edge, then advance the model with the inputs that were sampled.
   task automatic tick();
      logic pv, pp;
      @(posedge clk);
      pv = vi && en && (mq.size() < 2);
      pp = ri && en && (mq.size() > 0);
      if (rst || clr) begin
         mq.delete();
         mw = 0;
      end else begin
         if (pp) begin
            if (mw == 3) begin
               mw = 0;
               void'(mq.pop_front());
            end else begin
               mw++;
            end
         end
         if (pv) begin
            mq.push_back(blk);
            if (src.size() > 0) void'(src.pop_front());
         end
      end
      @(negedge clk);
   endtask

   // Upstream producer holds its head block on valid_i until accepted.
   task automatic step(input logic r, input logic c, input logic e, input logic rr,
                       input string tag);
      logic v;
      logic [127:0] b;
      v = (src.size() > 0);
      b = v ? src[0] : '0;
      drive(r, c, e, v, b, rr);
      check_model(tag);
   endtask

   task automatic run(input int n, input logic rr, input string tag);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, 1'b1, rr, tag);
         tick();
      end
   endtask

   initial begin
      int wc, bad, first_c, last_c;
      logic r, c, e, rr;

      tbl[0]  = '{1'b1, BLK1, 1'b0, 32'h0,        32'h0,        1'b0, 2'd0, 1'b1};
      tbl[1]  = '{1'b0, '0,   1'b1, 32'hAAAAAAAA, 32'h55555555, 1'b0, 2'd1, 1'b1};
      tbl[2]  = '{1'b0, '0,   1'b1, 32'hBBBBBBBB, 32'h78563412, 1'b0, 2'd1, 1'b1};
      tbl[3]  = '{1'b0, '0,   1'b1, 32'h12345678, 32'hBBBBBBBB, 1'b0, 2'd1, 1'b1};
      tbl[4]  = '{1'b0, '0,   1'b1, 32'h55555555, 32'hAAAAAAAA, 1'b1, 2'd1, 1'b1};
      tbl[5]  = '{1'b1, BLK2, 1'b0, 32'h0,        32'h0,        1'b0, 2'd0, 1'b1};
      tbl[6]  = '{1'b0, '0,   1'b1, 32'hFFFFFFFF, 32'h78563412, 1'b0, 2'd1, 1'b1};
      tbl[7]  = '{1'b0, '0,   1'b1, 32'h00000000, 32'h00000000, 1'b0, 2'd1, 1'b1};
      tbl[8]  = '{1'b0, '0,   1'b1, 32'h00000000, 32'h00000000, 1'b0, 2'd1, 1'b1};
      tbl[9]  = '{1'b0, '0,   1'b1, 32'h12345678, 32'hFFFFFFFF, 1'b1, 2'd1, 1'b1};
      tbl[10] = '{1'b0, '0,   1'b0, 32'h0,        32'h0,        1'b0, 2'd0, 1'b1};

      rst = 1'b1; clr = 1'b0; en = 1'b1; vi = 1'b0; blk = '0; ri = 1'b1;
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1);
      tick();

      // Word order, byte swap and last marker for both parameterizations.
      for (int i = 0; i < 11; i++) begin
         drive(1'b0, 1'b0, 1'b1, tbl[i].vi, tbl[i].blk, 1'b1);
         chk($sformatf("tbl%0d.valid", i), 32'(val0),  32'(tbl[i].ev));
         chk($sformatf("tbl%0d.w0", i),    wd0,        tbl[i].ew0);
         chk($sformatf("tbl%0d.w1", i),    wd1,        tbl[i].ew1);
         chk($sformatf("tbl%0d.last", i),  32'(last0), 32'(tbl[i].el));
         chk($sformatf("tbl%0d.occ", i),   32'(occ0),  32'(tbl[i].eo));
         chk($sformatf("tbl%0d.ready", i), 32'(rdy0),  32'(tbl[i].er));
         check_model($sformatf("tbl%0d", i));
         tick();
      end

      // Back-to-back blocks: 12 contiguous words, last on every 4th.
      for (int i = 0; i < 3; i++) src.push_back({$urandom, $urandom, $urandom, $urandom});
      wc = 0; bad = 0; first_c = -1; last_c = -1;
      for (int i = 0; i < 18; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1, "b2b");
         if (val0) begin
            wc++;
            if (first_c < 0) first_c = i;
            last_c = i;
            if (last0 && (wc % 4 != 0)) bad++;
            if (!last0 && (wc % 4 == 0)) bad++;
         end
         tick();
      end
      chk("b2b.words", 32'(wc), 32'd12);
      chk("b2b.lastpos", 32'(bad), 32'd0);
      chk("b2b.span", 32'(last_c - first_c + 1), 32'd12);

      // Backpressure on word 1 while more blocks wait upstream.
      src.push_back(BLK1);
      step(1'b0, 1'b0, 1'b1, 1'b1, "bp"); tick();
      src.push_back({$urandom, $urandom, $urandom, $urandom});
      src.push_back({$urandom, $urandom, $urandom, $urandom});
      step(1'b0, 1'b0, 1'b1, 1'b1, "bp"); tick();
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, "bp.stall");
         chk("bp.hold_word", wd0, 32'hBBBBBBBB);
         chk("bp.hold_valid", 32'(val0), 32'd1);
         tick();
      end
      chk("bp.full_ready", 32'(rdy0), 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b1, "bp.resume"); tick();
      chk("bp.next_word", wd0, 32'h12345678);
      run(16, 1'b1, "bp.drain");

      // Soft clear mid-block with both slots full.
      src.push_back(BLK1);
      src.push_back(BLK2);
      run(4, 1'b1, "clr.fill");
      chk("clr.pre_occ", 32'(occ0), 32'd2);
      step(1'b0, 1'b1, 1'b1, 1'b1, "clr.pulse"); tick();
      step(1'b0, 1'b0, 1'b1, 1'b1, "clr.after");
      chk("clr.valid", 32'(val0), 32'd0);
      chk("clr.occ", 32'(occ0), 32'd0);
      chk("clr.ready", 32'(rdy0), 32'd1);
      tick();
      src.push_back(BLK1);
      step(1'b0, 1'b0, 1'b1, 1'b1, "clr.push"); tick();
      step(1'b0, 1'b0, 1'b1, 1'b1, "clr.word0");
      chk("clr.word0", wd0, 32'hAAAAAAAA);
      tick();
      run(6, 1'b1, "clr.drain");

      // Enable low during word 1 with an upstream block pending.
      src.push_back(BLK1);
      step(1'b0, 1'b0, 1'b1, 1'b1, "en.push"); tick();
      step(1'b0, 1'b0, 1'b1, 1'b1, "en.w0"); tick();
      src.push_back(BLK2);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, "en.off");
         chk("en.valid", 32'(val0), 32'd0);
         chk("en.ready", 32'(rdy0), 32'd0);
         chk("en.occ", 32'(occ0), 32'd1);
         tick();
      end
      step(1'b0, 1'b0, 1'b1, 1'b1, "en.on");
      chk("en.resume_word", wd0, 32'hBBBBBBBB);
      tick();
      run(12, 1'b1, "en.drain");

      // Reset while valid_i is high: block must not be captured.
      src.push_back(BLK2);
      step(1'b1, 1'b0, 1'b1, 1'b1, "rst.pulse"); tick();
      step(1'b0, 1'b0, 1'b1, 1'b1, "rst.after");
      chk("rst.occ", 32'(occ0), 32'd0);
      chk("rst.valid", 32'(val0), 32'd0);
      chk("rst.word", wd0, 32'd0);
      chk("rst.last", 32'(last0), 32'd0);
      chk("rst.ready", 32'(rdy0), 32'd1);
      tick();
      run(8, 1'b1, "rst.drain");

      // Randomized traffic with occasional stalls, disables, clears and resets.
      for (int i = 0; i < 400; i++) begin
         if (src.size() < 2 && ($urandom % 3) == 0)
            src.push_back({$urandom, $urandom, $urandom, $urandom});
         r  = (($urandom % 97) == 0);
         c  = (($urandom % 53) == 0);
         e  = (($urandom % 8) != 0);
         rr = (($urandom % 4) != 0);
         step(r, c, e, rr, "rand");
         tick();
      end
      run(16, 1'b1, "rand.drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
